aes_job_sequencer: RTL and testbench

- TL-UL host that drives the AES IP through its register interface, one 128-bit block per job.
- Accepts a job (op, 128-bit key, 128-bit input block) on a valid/ready port.
- Programs CTRL, KEY0-3 and DATA_IN0-3, polls STATUS until OUTPUT_VALID is set, reads DATA_OUT0-3, then returns the result on a valid/ready port.
- Sits between an on-chip requester and the aes TL-UL device port, replacing software sequencing.

---
 rtl/aes_job_sequencer_pkg.sv | 29 ++
 rtl/tlul_pkg.sv | 25 ++
 rtl/aes_seq_tl_if.sv | 19 +
 rtl/aes_seq_tl_port.sv | 58 +++++
 rtl/aes_job_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_aes_job_sequencer.sv | 297 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/aes_job_sequencer_pkg.sv
// Shared types for the AES job sequencer: FSM state enum, TL opcodes,
// the captured job record and a register-word address helper.
package aes_job_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_CTRL,
    WR_KEY,
    WR_DIN,
    POLL,
    RD_OUT,
    RESP
  } aes_seq_state_e;

  localparam logic [2:0] PutFullData = 3'h0;
  localparam logic [2:0] Get         = 3'h4;

  typedef struct packed {
    logic         op;    // 0 = encrypt, 1 = decrypt
    logic [127:0] key;
    logic [127:0] data;
  } aes_job_t;

  // Byte address of 32-bit word idx of a four-word register bank.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [1:0] idx);
    return base + {28'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL channel types shared by the AES job sequencer and its device.
// tl_h2d_t carries the A channel plus d_ready; tl_d2h_t carries the D channel plus a_ready.
package tlul_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [7:0]  d_source;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/aes_seq_tl_if.sv
// Single-transaction link between the sequencer FSM and its TL-UL host port.
// Handshake: the master raises req with we/addr/wdata and keeps all four
// stable until done pulses for one cycle; done carries rdata and err for
// that transaction. req may stay high after done to start the next one.
// Ports (modports):
//   master : drives req, we, addr, wdata; samples done, rdata, err
//   slave  : the reverse
interface aes_seq_tl_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        done;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, we, addr, wdata, input done, rdata, err);
  modport slave  (input req, we, addr, wdata, output done, rdata, err);
endinterface

// File: rtl/aes_seq_tl_port.sv
// Single-outstanding TL-UL host adapter.
// Turns one req/done transaction into an A-phase (PutFullData or Get,
// 32-bit, full mask) and waits for its D-phase before the next A-phase.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : request/done link from the sequencer FSM (slave side)
//   tl_o, tl_i   : TL-UL host request / device response
module aes_seq_tl_port
  import aes_job_sequencer_pkg::*;
#(
  parameter logic [7:0] SourceId = 8'h00
) (
  input  logic               clk_i,
  input  logic               rst_i,
  aes_seq_tl_if.slave        bus,
  output tlul_pkg::tl_h2d_t  tl_o,
  input  tlul_pkg::tl_d2h_t  tl_i
);

  logic d_wait_q;  // an A-phase was accepted and its D-phase is pending
  logic a_fire;
  logic d_fire;

  assign a_fire = tl_o.a_valid && tl_i.a_ready;
  // A D-phase counts only while one is expected; anything else (for
  // example a response left over from before a reset) is dropped.
  assign d_fire = d_wait_q && tl_i.d_valid && (tl_i.d_source == SourceId);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      d_wait_q <= 1'b0;
    end else if (d_fire) begin
      d_wait_q <= 1'b0;
    end else if (a_fire) begin
      d_wait_q <= 1'b1;
    end
  end

  // a_valid follows req directly so an accepted A-phase can be answered
  // in the next cycle; the master holds the fields stable until done.
  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = bus.req && !d_wait_q;
    tl_o.a_opcode  = bus.we ? PutFullData : Get;
    tl_o.a_param   = 3'h0;
    tl_o.a_size    = 2'd2;
    tl_o.a_source  = SourceId;
    tl_o.a_address = bus.addr;
    tl_o.a_mask    = 4'hF;
    tl_o.a_data    = bus.we ? bus.wdata : 32'h0;
    tl_o.d_ready   = 1'b1;
  end

  assign bus.done  = d_fire;
  assign bus.rdata = tl_i.d_data;
  assign bus.err   = tl_i.d_error;

endmodule

// File: rtl/aes_job_sequencer.sv
// TL-UL host that runs one AES-128 block per job on the AES register block:
// CTRL write, KEY0-3 writes, DATA_IN0-3 writes (the last starts the core),
// STATUS polling until OUTPUT_VALID, DATA_OUT0-3 reads, then a response.
// A d_error or a poll timeout aborts to the response with rsp_err_o = 1
// and rsp_data_o = 0.
// Optional feature: define AES_JOB_SEQUENCER_KEY_CACHE_EN to remember the
// key of the last successful job and skip KEY writes when it repeats.
// Ports:
//   clk_i, rst_i                          : clock, async active-high reset
//   req_valid_i/req_ready_o, req_op_i,
//   req_key_i, req_data_i                 : job request (valid/ready)
//   rsp_valid_o/rsp_ready_i, rsp_data_o,
//   rsp_err_o                             : job result (valid/ready)
//   busy_o                                : job in flight
//   tl_o, tl_i                            : TL-UL host port to the AES
module aes_job_sequencer
  import aes_job_sequencer_pkg::*;
#(
  parameter logic [31:0] CtrlOffset        = 32'h50,
  parameter logic [31:0] KeyOffset         = 32'h00,
  parameter logic [31:0] DataInOffset      = 32'h30,
  parameter logic [31:0] DataOutOffset     = 32'h40,
  parameter logic [31:0] StatusOffset      = 32'h58,
  parameter int unsigned StatusOutValidBit = 3,
  parameter logic [31:0] CtrlEncVal        = 32'h0000_0002,
  parameter logic [31:0] CtrlDecVal        = 32'h0000_0003,
  parameter logic [15:0] PollTimeout       = 16'd1024,
  parameter logic [7:0]  SourceId          = 8'h00
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_op_i,
  input  logic [127:0]       req_key_i,
  input  logic [127:0]       req_data_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [127:0]       rsp_data_o,
  output logic               rsp_err_o,
  output logic               busy_o,
  output tlul_pkg::tl_h2d_t  tl_o,
  input  tlul_pkg::tl_d2h_t  tl_i
);

  aes_seq_state_e state_q, state_d;
  logic [1:0]     idx_q, idx_d;
  logic [15:0]    poll_cnt_q;
  aes_job_t       job_q;
  logic [127:0]   result_q;
  logic           err_q;

  logic capture;
  logic abort;
  logic poll_miss;
  logic store_word;
  logic txn_ok;
  logic key_hit;

  aes_seq_tl_if tl_bus ();

  aes_seq_tl_port #(
    .SourceId(SourceId)
  ) u_tl_port (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (tl_bus),
    .tl_o (tl_o),
    .tl_i (tl_i)
  );

  // ---------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    abort      = 1'b0;
    poll_miss  = 1'b0;
    store_word = 1'b0;
    txn_ok     = tl_bus.done && !tl_bus.err;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          capture = 1'b1;
          state_d = WR_CTRL;
        end
      end
      WR_CTRL: if (txn_ok) state_d = key_hit ? WR_DIN : WR_KEY;
      WR_KEY:  if (txn_ok && idx_q == 2'd3) state_d = WR_DIN;
      WR_DIN:  if (txn_ok && idx_q == 2'd3) state_d = POLL;
      POLL: begin
        if (txn_ok) begin
          if (tl_bus.rdata[StatusOutValidBit]) begin
            state_d = RD_OUT;
          end else if (poll_cnt_q == PollTimeout - 16'd1) begin
            abort = 1'b1;  // this was the last permitted STATUS read
          end else begin
            poll_miss = 1'b1;
          end
        end
      end
      RD_OUT: begin
        if (txn_ok) begin
          store_word = 1'b1;
          if (idx_q == 2'd3) state_d = RESP;
        end
      end
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (tl_bus.done && tl_bus.err) abort = 1'b1;
    if (abort) state_d = RESP;

    // Word index restarts on every state entry.
    if (state_d != state_q) begin
      idx_d = 2'd0;
    end else if (txn_ok) begin
      idx_d = idx_q + 2'd1;
    end else begin
      idx_d = idx_q;
    end
  end

  // ---------------------------------------------------------------------
  // Register access for the current state; fields only move on done.
  // ---------------------------------------------------------------------
  always_comb begin
    tl_bus.req   = 1'b0;
    tl_bus.we    = 1'b0;
    tl_bus.addr  = 32'h0;
    tl_bus.wdata = 32'h0;
    case (state_q)
      WR_CTRL: begin
        tl_bus.req   = 1'b1;
        tl_bus.we    = 1'b1;
        tl_bus.addr  = CtrlOffset;
        tl_bus.wdata = job_q.op ? CtrlDecVal : CtrlEncVal;
      end
      WR_KEY: begin
        tl_bus.req   = 1'b1;
        tl_bus.we    = 1'b1;
        tl_bus.addr  = word_addr(KeyOffset, idx_q);
        tl_bus.wdata = job_q.key[{idx_q, 5'b0} +: 32];
      end
      WR_DIN: begin
        tl_bus.req   = 1'b1;
        tl_bus.we    = 1'b1;
        tl_bus.addr  = word_addr(DataInOffset, idx_q);
        tl_bus.wdata = job_q.data[{idx_q, 5'b0} +: 32];
      end
      POLL: begin
        tl_bus.req  = 1'b1;
        tl_bus.addr = StatusOffset;
      end
      RD_OUT: begin
        tl_bus.req  = 1'b1;
        tl_bus.addr = word_addr(DataOutOffset, idx_q);
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      poll_cnt_q <= 16'd0;
      job_q      <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (capture) begin
        job_q      <= '{op: req_op_i, key: req_key_i, data: req_data_i};
        err_q      <= 1'b0;
        poll_cnt_q <= 16'd0;
      end
      if (poll_miss) poll_cnt_q <= poll_cnt_q + 16'd1;
      if (store_word) result_q[{idx_q, 5'b0} +: 32] <= tl_bus.rdata;
      if (abort) begin
        err_q    <= 1'b1;
        result_q <= '0;
      end
    end
  end

`ifdef AES_JOB_SEQUENCER_KEY_CACHE_EN
  logic [127:0] cache_key_q;
  logic         cache_vld_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cache_key_q <= '0;
      cache_vld_q <= 1'b0;
    end else if (abort) begin
      cache_vld_q <= 1'b0;
    end else if (state_q == RD_OUT && state_d == RESP) begin
      // Successful completion: the AES now holds this key.
      cache_key_q <= job_q.key;
      cache_vld_q <= 1'b1;
    end
  end

  assign key_hit = cache_vld_q && (cache_key_q == job_q.key);
`else
  assign key_hit = 1'b0;
`endif

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign busy_o      = (state_q != IDLE);
  assign rsp_data_o  = result_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_aes_job_sequencer.sv
// Directed bench for aes_job_sequencer with a small TL-UL AES register model.
module tb_aes_job_sequencer;
  import tlul_pkg::*;

  localparam logic [127:0] FipsKey = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FipsPt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FipsCt  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] BadOut  = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

`ifdef AES_JOB_SEQUENCER_KEY_CACHE_EN
  localparam int RepeatKeyWr = 0;
  localparam int RepeatTxn   = 10;
`else
  localparam int RepeatKeyWr = 4;
  localparam int RepeatTxn   = 14;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT signals
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_op = 1'b0;
  logic [127:0] req_key = '0;
  logic [127:0] req_data = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [127:0] rsp_data;
  logic         rsp_err;
  logic         busy;
  tl_h2d_t      tl_o;
  tl_d2h_t      tl_i;

  aes_job_sequencer #(.PollTimeout(16'd8)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_op_i   (req_op),
    .req_key_i  (req_key),
    .req_data_i (req_data),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_data_o (rsp_data),
    .rsp_err_o  (rsp_err),
    .busy_o     (busy),
    .tl_o       (tl_o),
    .tl_i       (tl_i)
  );

  // scoreboard counters
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [131:0] obs, input logic [131:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // AES register model (zero-wait device)
  // ---------------------------------------------------------------------
  logic [31:0]  m_key[4];
  logic [31:0]  m_din[4];
  logic [31:0]  m_ctrl = '0;
  logic [127:0] m_out = '0;
  int           m_polls = 0;
  bit           never_valid = 1'b0;
  logic [31:0]  err_addr = 32'hffff_ffff;
  int           stall_left = 0;
  int           n_txn = 0, n_key_wr = 0, n_status = 0, n_bad = 0;
  logic         d_valid_q = 1'b0;
  logic [31:0]  d_data_q = '0;
  logic         d_err_q = 1'b0;

  function automatic logic [127:0] model_out(input logic [31:0] c, input logic [127:0] k,
                                             input logic [127:0] d);
    if (c == 32'h2 && k == FipsKey && d == FipsPt) return FipsCt;
    if (c == 32'h3 && k == FipsKey && d == FipsCt) return FipsPt;
    return BadOut;
  endfunction

  always_comb begin
    tl_i          = '0;
    tl_i.d_valid  = d_valid_q;
    tl_i.d_source = 8'h00;
    tl_i.d_data   = d_data_q;
    tl_i.d_error  = d_err_q;
    tl_i.a_ready  = (stall_left == 0);
  end

  always @(posedge clk) begin
    logic [31:0] a;
    logic [1:0]  w;
    logic        is_wr;
    logic        ok;
    d_valid_q <= 1'b0;
    d_err_q   <= 1'b0;
    d_data_q  <= '0;
    a = tl_o.a_address;
    w = a[3:2];
    if (tl_o.a_valid && stall_left > 0) begin
      stall_left <= stall_left - 1;
    end else if (tl_o.a_valid) begin
      n_txn++;
      if (tl_o.a_size != 2'd2 || tl_o.a_mask != 4'hf || tl_o.a_source != 8'h00) n_bad++;
      if (d_valid_q) n_bad++;  // second A-phase while a response is on D
      d_valid_q <= 1'b1;
      d_err_q   <= (a == err_addr);
      is_wr = (a == 32'h50) || (a[31:4] == 28'h0) || (a[31:4] == 28'h3);
      if (is_wr && tl_o.a_opcode != 3'h0) n_bad++;
      if (!is_wr && tl_o.a_opcode != 3'h4) n_bad++;
      if (a == 32'h50) begin
        m_ctrl = tl_o.a_data;
      end else if (a[31:4] == 28'h0) begin
        m_key[w] = tl_o.a_data;
        n_key_wr++;
      end else if (a[31:4] == 28'h3) begin
        m_din[w] = tl_o.a_data;
        if (w == 2'd3) begin
          m_out   = model_out(m_ctrl, {m_key[3], m_key[2], m_key[1], m_key[0]},
                              {m_din[3], m_din[2], m_din[1], m_din[0]});
          m_polls = 0;
        end
      end else if (a == 32'h58) begin
        n_status++;
        m_polls++;
        ok = !never_valid && m_polls >= 1;
        d_data_q <= {28'h0, ok, 3'b000};
      end else if (a[31:4] == 28'h4) begin
        d_data_q <= m_out[{w, 5'b0} +: 32];
      end else begin
        n_bad++;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks (entered and left on a falling edge)
  // ---------------------------------------------------------------------
  int cap_cyc = 0;

  task automatic send_job(input logic op, input logic [127:0] key, input logic [127:0] data);
    n_txn = 0; n_key_wr = 0; n_status = 0;
    req_valid = 1'b1; req_op = op; req_key = key; req_data = data;
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    check_eq("req_ready_seen", req_ready, 1'b1);
    @(posedge clk);
    #1;
    cap_cyc   = cyc;
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_rsp(output logic [127:0] d, output logic e, output int lat);
    for (int i = 0; i < 3000 && !rsp_valid; i++) @(negedge clk);
    check_eq("rsp_valid_seen", rsp_valid, 1'b1);
    d   = rsp_data;
    e   = rsp_err;
    lat = cyc - cap_cyc;
  endtask

  task automatic ack_rsp(input int hold, input logic [127:0] d, input logic e);
    for (int i = 0; i < hold; i++) begin
      check_eq("rsp_hold_stable", {rsp_valid, rsp_err, req_ready, rsp_data}, {1'b1, e, 1'b0, d});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("idle_after_rsp", {busy, req_ready, rsp_valid}, 3'b010);
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  logic [127:0] got_d;
  logic         got_e;
  int           lat;
  tl_h2d_t      a_ref;

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", req_ready, 1'b1);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_rsp_data", rsp_data, 128'h0);
    check_eq("rst_rsp_err", rsp_err, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_a_valid", tl_o.a_valid, 1'b0);
    check_eq("rst_d_ready", tl_o.d_ready, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 encrypt
    send_job(1'b0, FipsKey, FipsPt);
    check_eq("enc_busy", busy, 1'b1);
    wait_rsp(got_d, got_e, lat);
    check_eq("enc_data", got_d, FipsCt);
    check_eq("enc_err", got_e, 1'b0);
    check_eq("enc_latency_ge28", lat >= 28, 1'b1);
    check_eq("enc_txn", n_txn, 14);
    ack_rsp(2, FipsCt, 1'b0);

    // decrypt with the same key (key writes skipped when cached)
    send_job(1'b1, FipsKey, FipsCt);
    wait_rsp(got_d, got_e, lat);
    check_eq("dec_data", got_d, FipsPt);
    check_eq("dec_err", got_e, 1'b0);
    check_eq("dec_txn", n_txn, RepeatTxn);
    check_eq("dec_key_wr", n_key_wr, RepeatKeyWr);
    ack_rsp(1, FipsPt, 1'b0);

    // d_error on the KEY2 write
    err_addr = 32'h08;
    send_job(1'b0, 128'h1, FipsPt);
    wait_rsp(got_d, got_e, lat);
    check_eq("derr_err", got_e, 1'b1);
    check_eq("derr_data", got_d, 128'h0);
    ack_rsp(5, 128'h0, 1'b1);
    check_eq("derr_txn", n_txn, 4);
    err_addr = 32'hffff_ffff;

    // STATUS never valid: timeout after 8 polls
    never_valid = 1'b1;
    send_job(1'b0, FipsKey, FipsPt);
    wait_rsp(got_d, got_e, lat);
    check_eq("tmo_status_gets", n_status, 8);
    check_eq("tmo_err", got_e, 1'b1);
    check_eq("tmo_data", got_d, 128'h0);
    ack_rsp(1, 128'h0, 1'b1);
    never_valid = 1'b0;

    // a_ready low for 5 cycles, rsp_ready low for 10 cycles
    stall_left = 5;
    send_job(1'b0, FipsKey, FipsPt);
    a_ref = tl_o;
    check_eq("stall_a_valid", a_ref.a_valid, 1'b1);
    check_eq("stall_a_addr", a_ref.a_address, 32'h50);
    check_eq("stall_a_data", a_ref.a_data, 32'h2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall_a_stable", tl_o, a_ref);
    end
    wait_rsp(got_d, got_e, lat);
    check_eq("stall_data", got_d, FipsCt);
    check_eq("stall_txn", n_txn, 14);
    ack_rsp(10, FipsCt, 1'b0);

    // reset while polling, then reissue the encrypt
    never_valid = 1'b1;
    send_job(1'b0, FipsKey, FipsPt);
    for (int i = 0; i < 200 && n_status < 2; i++) @(negedge clk);
    check_eq("rst_poll_reached", n_status >= 2, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_a_valid", tl_o.a_valid, 1'b0);
    check_eq("rst_mid_state", {busy, req_ready, rsp_valid}, 3'b010);
    @(negedge clk);
    rst = 1'b0;
    never_valid = 1'b0;
    @(negedge clk);
    send_job(1'b0, FipsKey, FipsPt);
    wait_rsp(got_d, got_e, lat);
    check_eq("reissue_data", got_d, FipsCt);
    check_eq("reissue_err", got_e, 1'b0);
    check_eq("reissue_txn", n_txn, 14);
    ack_rsp(1, FipsCt, 1'b0);

    // second same-key job after a clean one
    send_job(1'b1, FipsKey, FipsCt);
    wait_rsp(got_d, got_e, lat);
    check_eq("repeat_data", got_d, FipsPt);
    check_eq("repeat_txn", n_txn, RepeatTxn);
    check_eq("repeat_key_wr", n_key_wr, RepeatKeyWr);
    ack_rsp(1, FipsPt, 1'b0);

    check_eq("tl_protocol_bad", n_bad, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
